// File: rtl/soc_evt_tx_pkg.sv
// soc_evt_tx_pkg: shared types, widths and round-robin pick helper for the SoC event stream transmitter.
package soc_evt_tx_pkg;
  localparam int LOST_CNT_W = 16;
  localparam int EVNT_W_DEF = 8;
  localparam int MAX_SRC = 256;
  localparam int IDX_W = 8;
  typedef logic [EVNT_W_DEF-1:0] evt_id_t;
  typedef struct packed {
    logic vld;
    logic [IDX_W-1:0] idx;
  } rr_t;
  // First set bit at or after ptr among the n low bits, wrapping at n; scanned downward so the nearest wins.
  function automatic rr_t rr_pick(input logic [MAX_SRC-1:0] pend, input logic [IDX_W-1:0] ptr, input int n);
    rr_t r;
    int j;
    r = '0;
    for (int k = MAX_SRC - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && pend[j[IDX_W-1:0]]) begin
        r.vld = 1'b1;
        r.idx = j[IDX_W-1:0];
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/soc_evt_tx_fifo.sv
// soc_evt_tx_fifo: synchronous FIFO with simultaneous push/pop when full and a register-backed head.
module soc_evt_tx_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] data_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  assign full_o = cnt == (AW+1)'(DEPTH);
  assign empty_o = cnt == '0;
  assign data_o = empty_o ? '0 : mem[rd];
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (push_i) wr <= wr + 1'b1;
      if (pop_i) rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk_i)
    if (push_i) mem[wr] <= data_i;
endmodule

// File: rtl/soc_evt_stream_tx.sv
// soc_evt_stream_tx: captures SoC event pulses, round-robin queues their IDs and streams them via valid/ready.
// Optional saturating lost-event counter enabled by SOC_EVT_TX_LOST_CNT_EN.
module soc_evt_stream_tx
  import soc_evt_tx_pkg::*;
#(
  parameter int NB_SRC = 16,
  parameter int EVNT_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int EVT_ID_BASE = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NB_SRC-1:0]     src_evt_i,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [EVNT_WIDTH-1:0] evt_data_o,
  output logic [NB_SRC-1:0]     lost_o,
  input  logic                  lost_clr_i,
  output logic [LOST_CNT_W-1:0] lost_cnt_o,
  output logic                  busy_o
);
  logic [NB_SRC-1:0] pend, gnt_vec, lost_set;
  logic [MAX_SRC-1:0] pend_ext;
  logic [IDX_W-1:0] ptr;
  logic [EVNT_WIDTH-1:0] id;
  rr_t g;
  logic push, pop, full, empty;
  assign evt_valid_o = !empty;
  assign pop = evt_valid_o && evt_ready_i;
  assign busy_o = |pend || !empty;
  always_comb begin
    pend_ext = '0;
    pend_ext[NB_SRC-1:0] = pend;
    g = rr_pick(pend_ext, ptr, NB_SRC);
    push = g.vld && (!full || pop);
    for (int i = 0; i < NB_SRC; i++) gnt_vec[i] = push && g.idx == IDX_W'(i);
    lost_set = src_evt_i & pend & ~gnt_vec;
    id = EVNT_WIDTH'(EVT_ID_BASE + int'(g.idx));
  end
  // A pulse on the source being granted re-arms its pending bit rather than counting as a loss.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend <= '0;
      ptr <= '0;
      lost_o <= '0;
    end else begin
      pend <= (pend & ~gnt_vec) | src_evt_i;
      if (push) ptr <= g.idx == IDX_W'(NB_SRC - 1) ? '0 : g.idx + 1'b1;
      lost_o <= lost_clr_i ? '0 : lost_o | lost_set;
    end
  end
  soc_evt_tx_fifo #(.W(EVNT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .push_i(push),
    .data_i(id),
    .pop_i(pop),
    .full_o(full),
    .empty_o(empty),
    .data_o(evt_data_o)
  );
`ifdef SOC_EVT_TX_LOST_CNT_EN
  logic [LOST_CNT_W-1:0] cnt;
  logic [LOST_CNT_W:0] cnt_sum;
  always_comb begin
    cnt_sum = {1'b0, cnt};
    for (int i = 0; i < NB_SRC; i++) cnt_sum = cnt_sum + {{LOST_CNT_W{1'b0}}, lost_set[i]};
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni || lost_clr_i) cnt <= '0;
    else cnt <= cnt_sum[LOST_CNT_W] ? '1 : cnt_sum[LOST_CNT_W-1:0];
  end
  assign lost_cnt_o = cnt;
`else
  assign lost_cnt_o = '0;
`endif
endmodule

// File: doc/soc_evt_stream_tx.md
Name: soc_evt_stream_tx

Overview:
- SoC-side transmitter for the cluster's SoC-peripheral event stream; drives the soc_periph_evt valid/ready/data handshake that the cluster event unit consumes.
- Captures single-cycle event pulses from NB_SRC SoC peripherals into per-source pending bits.
- Round-robin arbitration selects one pending source per cycle and pushes its ID into a FIFO.
- Streams the FIFO head to the cluster under valid/ready flow control.

Parameters:
- NB_SRC, 16, number of SoC event sources; must be >= 2 and <= 2**EVNT_WIDTH.
- EVNT_WIDTH, 8, width of the event ID on the stream.
- FIFO_DEPTH, 4, number of FIFO entries; power of 2, >= 2.
- EVT_ID_BASE, 0, value added to the source index to form the event ID; result is truncated to EVNT_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- src_evt_i  in  NB_SRC  event pulses, one bit per source; each set bit is one event for that cycle.
- evt_valid_o  out  1  event available; connects to the cluster's soc_periph_evt_valid_i.
- evt_ready_i  in  1  cluster accepts the event; connects to soc_periph_evt_ready_o.
- evt_data_o  out  EVNT_WIDTH  event ID; connects to soc_periph_evt_data_i.
- lost_o  out  NB_SRC  sticky per-source lost-event flags.
- lost_clr_i  in  1  clears lost_o, and the lost counter when present.
- lost_cnt_o  out  16  saturating count of lost events across all sources.
- busy_o  out  1  high when any pending bit is set or the FIFO is non-empty.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - pending=0, FIFO empty, RR pointer=0, lost_o=0, lost counter=0.
  - Outputs: evt_valid_o=0, evt_data_o=0, busy_o=0, lost_cnt_o=0.
  - Reset mid-stream discards all queued and pending events and does not flag them as lost.
- Capture: pending[i] is set at the edge after src_evt_i[i]=1.
- Arbitration (combinational on pending):
  - Grant the first set pending bit at or after the RR pointer, wrapping at NB_SRC.
  - A push happens when any pending bit is set and (FIFO not full or pop this cycle).
  - On a push: clear the granted pending bit, write EVT_ID_BASE+index to the FIFO, set RR pointer = grant+1 mod NB_SRC.
  - At most one push per cycle.
- Same-cycle pulse and grant on source i: pending[i] stays set (new event). This is not a loss.
- Loss: src_evt_i[i]=1 while pending[i]=1 and i is not granted that cycle. Then lost_o[i] is set at the next edge and the counter increments by the number of such sources that cycle, saturating at 16'hFFFF.
- lost_clr_i has priority over a same-cycle set or increment.
- FIFO:
  - Pop when evt_valid_o && evt_ready_i.
  - Push and pop in the same cycle keep the occupancy unchanged. This includes the full case.
  - evt_valid_o = !empty. evt_data_o = head entry; evt_data_o = 0 when empty.
- Stream rule: while evt_valid_o=1 && evt_ready_i=0, evt_data_o and evt_valid_o hold stable.
- Latency: pulse at cycle N with empty FIFO and no contention gives evt_valid_o=1 at cycle N+2.
- Throughput: 1 event per cycle sustained while evt_ready_i=1.
- Backpressure: with the FIFO full and no pop, pending bits hold. Further pulses on those sources are lost; pulses on sources whose pending bit is clear are captured.

Optional Feature:
- Macro: SOC_EVT_TX_LOST_CNT_EN.
- Defined: the 16-bit saturating lost counter is implemented as described and driven on lost_cnt_o.
- Undefined: no counter register; lost_cnt_o is tied to 0. lost_o flags and lost_clr_i behave identically in both builds.

Decomposition:
- Shared package soc_evt_tx_pkg holds:
  - localparam LOST_CNT_W=16.
  - typedef evt_id_t (logic [EVNT_WIDTH-1:0], default 8).
  - function rr_pick(pending, ptr) returning grant index and a valid bit.
- Sub-module soc_evt_tx_fifo: synchronous FIFO with push/pop/full/empty, simultaneous push+pop when full, and a registered head.
- Pending, arbitration and loss logic stay in the top module.

Test Plan:
- Single event: pulse src_evt_i[3] at cycle 10, evt_ready_i=1, EVT_ID_BASE=0 -> evt_valid_o=1 at cycle 12 with evt_data_o=8'h03 for one cycle; busy_o falls afterwards.
- Simultaneous: pulse src 1, 5 and 9 in one cycle, RR pointer=0 -> stream emits 8'h01, 8'h05, 8'h09 on consecutive cycles; RR pointer ends at 10.
- Backpressure: evt_ready_i=0, pulse 6 distinct sources on separate cycles, FIFO_DEPTH=4 -> 4 entries queued, 2 bits remain pending. Raise evt_ready_i -> all 6 IDs are delivered in grant order and lost_o=0.
- Loss: FIFO full, pulse src 2 twice -> lost_o[2]=1 and lost_cnt_o=1 (0 when the macro is undefined). Assert lost_clr_i -> both return to 0.
- Same-cycle grant and pulse on src 0 -> two 8'h00 events are delivered and lost_o[0]=0.
- Reset mid-stream: 3 entries queued, rst_ni=0 for one cycle -> evt_valid_o=0 at the next edge, and no stale IDs appear after rst_ni=1.
